sobel_window_reader: RTL

SOBEL_WINDOW_READER -- requirements
Module: sobel_window_reader

---
 rtl/sobel_window_reader.sv | 92 +++++++++
 1 files changed

// File: rtl/sobel_window_reader.sv
// 3x3 sliding-window register plus raster position tracker; 1-cycle registered latency, Enable=0 stalls all state.
// Define SOBEL_WIN_FRAMEDONE_EN to add the FrameDone end-of-frame pulse output.
module sobel_window_reader #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Enable,
  input  logic [DATA_W-1:0]             DataIn,
  input  logic [DATA_W-1:0]             Row1In,
  input  logic [DATA_W-1:0]             Row2In,
  output logic [9*DATA_W-1:0]           Window,
  output logic                          WindowValid,
  output logic [$clog2(IMG_WIDTH)-1:0]  Col,
  output logic [$clog2(IMG_HEIGHT)-1:0] Row
`ifdef SOBEL_WIN_FRAMEDONE_EN
  ,
  output logic                          FrameDone
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  // Index [0][0] is P00 and lands in the MSBs of the packed window.
  logic [0:2][0:2][DATA_W-1:0] win_q, win_d;
  logic [CW-1:0]               col_q, col_d;
  logic [RW-1:0]               row_q, row_d;
  logic                        valid_q, valid_d;
  logic                        fd_q, fd_d;
  logic                        last_col, last_row;

  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RW'(IMG_HEIGHT - 1));

  always_comb begin
    win_d   = win_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    fd_d    = 1'b0;
    if (Enable) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = Row2In;
      win_d[1][2] = Row1In;
      win_d[2][2] = DataIn;
      // Columns 0/1 of a row still hold pixels from the previous row, so never flag them.
      valid_d = (col_q >= CW'(2)) && (row_q >= RW'(2));
      fd_d    = last_col && last_row;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      win_q   <= win_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
    end
  end

  assign Window      = win_q;
  assign WindowValid = valid_q;
  assign Col         = col_q;
  assign Row         = row_q;

`ifdef SOBEL_WIN_FRAMEDONE_EN
  assign FrameDone = fd_q;
`else
  logic unused_fd;
  assign unused_fd = fd_q;
`endif

endmodule
